// File: rtl/vital_mon_pkg.sv
// Shared types and helpers for the multi-channel vital-sign alarm monitor.
// Contents:
//   ch_state_t - per-channel FSM state (NORMAL, PENDING, ALARM, ACKED)
//   ST_W       - encoded state width, used for the packed debug state bus
//   ch_w()     - channel index width, max(1, clog2(n))
package vital_mon_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_NORMAL  = 2'd0,
    ST_PENDING = 2'd1,
    ST_ALARM   = 2'd2,
    ST_ACKED   = 2'd3
  } ch_state_t;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vital_channel_fsm.sv
// One monitored channel: range compare, debounce counter, alarm FSM,
// excursion direction capture and (with ESCALATE_EN) escalation timer.
// Optional feature macro: ESCALATE_EN.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   en             - a sample for this channel is present this cycle
//   data, lo, hi   - sample value and this channel's limits
//   ack            - level-sampled acknowledge
//   alarm, dir     - latched alarm and its direction (1 = high excursion)
//   escalate       - alarm left unacknowledged for ESC_CYCLES clocks
//   state          - current FSM state, exported for debug
module vital_channel_fsm
  import vital_mon_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEBOUNCE   = 3,
  parameter int ESC_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              ack,
  output logic              alarm,
  output logic              dir,
  output logic              escalate,
  output ch_state_t         state
);

  localparam int              CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  if (DEBOUNCE < 1 || ESC_CYCLES < 1) begin : g_bad_params
    $error("vital_channel_fsm: DEBOUNCE and ESC_CYCLES must be >= 1");
  end

  logic             is_high;
  logic             out_range;
  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dir_q, dir_d;
  logic             last_in_q;

  // lo > hi makes every sample out of range; that falls out of the compares.
  assign is_high   = data > hi;
  assign out_range = (data < lo) || is_high;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_NORMAL;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      last_in_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      if (en) last_in_q <= ~out_range;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      // NORMAL always holds a zero count, so cnt_inc is 1 there and both
      // states share the debounce path.
      ST_NORMAL, ST_PENDING: begin
        if (en) begin
          if (out_range) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = ST_ALARM;
              dir_d   = is_high;
            end else begin
              state_d = ST_PENDING;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_NORMAL;
          end
        end
      end
      ST_ALARM: begin
        // A same-cycle sample outranks the remembered status.
        if (ack) begin
          cnt_d   = '0;
          state_d = (en ? ~out_range : last_in_q) ? ST_NORMAL : ST_ACKED;
        end
      end
      ST_ACKED: begin
        if (en && !out_range) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign alarm = (state_q == ST_ALARM);
  assign dir   = dir_q;
  assign state = state_q;

`ifdef ESCALATE_EN
  localparam int               ESC_W   = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES) : 1;
  localparam logic [ESC_W-1:0] ESC_MAX = ESC_W'(ESC_CYCLES - 1);

  logic [ESC_W-1:0] esc_cnt_q;
  logic             esc_q;

  // Counter is 0 on the ALARM entry edge and saturates at ESC_CYCLES-1;
  // the flag registers one edge after saturation, i.e. ESC_CYCLES clocks
  // after alarm rose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      esc_cnt_q <= '0;
      esc_q     <= 1'b0;
    end else if (state_d != ST_ALARM) begin
      esc_cnt_q <= '0;
      esc_q     <= 1'b0;
    end else if (state_q == ST_ALARM) begin
      if (esc_cnt_q == ESC_MAX) esc_q <= 1'b1;
      else                      esc_cnt_q <= esc_cnt_q + ESC_W'(1);
    end
  end

  assign escalate = esc_q;
`else
  assign escalate = 1'b0;
`endif

endmodule

// File: rtl/multi_vital_alarm_monitor.sv
// N-channel vital-sign threshold monitor. Decodes a channel-tagged sample
// stream into per-channel enables, runs one vital_channel_fsm per channel
// and produces a lowest-index-first alarm summary.
// Optional feature macro: ESCALATE_EN (per-channel escalation timers).
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   sample_valid/ch/data     - sample stream; indices >= NUM_CH are ignored
//   lo_thresh, hi_thresh     - packed limits, channel i at [i*DATA_W +: DATA_W]
//   ack                      - per-channel acknowledge, level-sampled
//   alarm, alarm_dir         - latched alarms and excursion direction
//   alarm_any, top_ch        - OR of alarms, lowest alarmed channel (0 if none)
//   escalate                 - per-channel escalation (0 without ESCALATE_EN)
//   ch_state                 - packed per-channel FSM state, debug only
module multi_vital_alarm_monitor
  import vital_mon_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = 8,
  parameter  int DEBOUNCE   = 3,
  parameter  int ESC_CYCLES = 1000,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [CH_W-1:0]          sample_ch,
  input  logic [DATA_W-1:0]        sample_data,
  input  logic [NUM_CH*DATA_W-1:0] lo_thresh,
  input  logic [NUM_CH*DATA_W-1:0] hi_thresh,
  input  logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH-1:0]        alarm,
  output logic [NUM_CH-1:0]        alarm_dir,
  output logic                     alarm_any,
  output logic [CH_W-1:0]          top_ch,
  output logic [NUM_CH-1:0]        escalate,
  output logic [NUM_CH*ST_W-1:0]   ch_state
);

  // Only indices 0..NUM_CH-1 get a decoder, so an out-of-range index
  // enables nothing and every channel holds.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic en;
    assign en = sample_valid && (sample_ch == CH_W'(i));

    vital_channel_fsm #(
      .DATA_W    (DATA_W),
      .DEBOUNCE  (DEBOUNCE),
      .ESC_CYCLES(ESC_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .data    (sample_data),
      .lo      (lo_thresh[i*DATA_W +: DATA_W]),
      .hi      (hi_thresh[i*DATA_W +: DATA_W]),
      .ack     (ack[i]),
      .alarm   (alarm[i]),
      .dir     (alarm_dir[i]),
      .escalate(escalate[i]),
      .state   (ch_state[i*ST_W +: ST_W])
    );
  end

  assign alarm_any = |alarm;

  // Scan downward so the lowest alarmed index wins.
  always_comb begin
    top_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (alarm[i]) top_ch = CH_W'(i);
    end
  end

endmodule
